sram_weight_reader: RTL and testbench
=====================================

SRAM_WEIGHT_READER -- requirements
Module: sram_weight_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, SRAM address width.
REQ-002 SHALL have parameter DATA_W, default 32, SRAM word width.
REQ-003 SHALL have parameter DEPTH, default 16384, SRAM words; address wraps modulo DEPTH.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, launch request; sampled only in IDLE.
REQ-008 SHALL have port base_addr, input, ADDR_W, first word address.
REQ-009 SHALL have port length, input, 15, word count (0..16384).
REQ-010 SHALL have port busy, output, 1, high in any state except IDLE.
REQ-011 SHALL have port done, output, 1, one-cycle pulse at transfer completion.
REQ-012 SHALL have ports wea0 and wea1, output, 4 each, tied to 4'b0000 (read-only master).
REQ-013 SHALL have ports addr0 and addr1, output, ADDR_W each, registered SRAM addresses.
REQ-014 SHALL have ports wdata0 and wdata1, output, DATA_W each, tied to zero.
REQ-015 SHALL have ports rdata0 and rdata1, input, DATA_W each, SRAM read data.
REQ-016 SHALL have port out_valid, output, 1, beat available.
REQ-017 SHALL have port out_ready, input, 1, consumer accepts beat.
REQ-018 SHALL have port out_data, output, 2*DATA_W, {word addr+1, word addr}.
REQ-019 SHALL have port out_mask, output, 2, per-word valid; [1] low on odd tail.
REQ-020 SHALL have port out_last, output, 1, marks final beat.

Function
REQ-021 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-022 IDLE with start=1 and length>0: latch base_addr and length, go to RUN; with length=0: go to DONE, issue no reads.
REQ-023 RUN: each issue cycle drives addr0=A, addr1=(A+1) mod DEPTH, then advances A by 2 mod DEPTH and words_left by min(2, words_left).
REQ-024 SHALL issue only when FIFO occupancy + outstanding reads < FIFO_DEPTH; the FIFO never overflows.
REQ-025 SHALL capture rdata0/rdata1 into the FIFO exactly one clock after the edge at which the SRAM samples the address (1-cycle SRAM read latency).
REQ-026 After the last issue, SHALL go to DRAIN; after the last beat handshake, SHALL go to DONE; DONE pulses done for one cycle, then returns to IDLE.
REQ-027 SHALL complete a beat on out_valid & out_ready; out_data/out_mask/out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 With out_ready held at 1, SHALL sustain one beat per cycle; first out_valid SHALL appear 2 cycles after the start-accept edge.
REQ-029 SHALL ignore start while busy.
REQ-030 Odd length: final beat out_mask=2'b01; out_data upper word is don't-care but SHALL equal rdata1 as read.
REQ-031 Simultaneous FIFO push and pop SHALL leave occupancy unchanged.
REQ-032 addr0/addr1 SHALL hold their last values when not issuing.

Reset
REQ-033 rst=1 at any time, including mid-transfer, SHALL force IDLE, flush the FIFO and clear outstanding reads.
REQ-034 During and after reset: busy=0, done=0, out_valid=0, out_last=0, out_mask=0, out_data=0, addr0=0, addr1=0.

Structure
REQ-035 Shared package SHALL hold the FSM state enum, ADDR_W/DATA_W/DEPTH defaults and the length width.
REQ-036 Output buffer SHALL be a separate sub-module sync_fifo (width 2*DATA_W+3, depth FIFO_DEPTH).

Verification
REQ-037 Preload RAM[i]=i; base=0x0010, length=8, out_ready=1 -> 4 beats {0x11,0x10}..{0x17,0x16}, mask 2'b11, out_last on beat 4, done 1 cycle after.
REQ-038 base=0x3FFE, length=4 -> beats {0x3FFF,0x3FFE}, {0x0001,0x0000}; addr wraps to 0.
REQ-039 base=0x0020, length=5 -> 3 beats; last beat mask=2'b01, lower word 0x24, out_last=1.
REQ-040 length=8, out_ready toggling 1,0,0,1 -> no lost or duplicated words; data stable while stalled; addresses pause at FIFO full.
REQ-041 length=0 -> done pulse 1 cycle after start, zero out_valid, addresses unchanged.
REQ-042 rst asserted on 3rd beat of length=16 -> next cycle busy=0, out_valid=0; new start with length=2 then reads correctly.

Source files
------------

// File: rtl/sram_weight_reader_pkg.sv
// Shared types and defaults for the SRAM weight reader.
// Holds the FSM state encoding, width defaults and the length field width.
package sram_weight_reader_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 16384;
    localparam int LEN_W      = 15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/sram_weight_reader_sync_fifo.sv
// Synchronous FIFO used as the reader's output beat buffer.
// Ports: clk, rst (sync, active high), push/wdata, pop/rdata, empty, count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        // Push and pop together leave occupancy unchanged.
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/sram_weight_reader.sv
// Streams word pairs from a dual-port read-only SRAM into a valid/ready beat stream.
// Ports: start/base_addr/length launch, busy/done status, SRAM ports 0/1, out_* beat stream.
module sram_weight_reader
    import sram_weight_reader_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [LEN_W-1:0]    length,
    output logic                busy,
    output logic                done,
    output logic [3:0]          wea0,
    output logic [3:0]          wea1,
    output logic [ADDR_W-1:0]   addr0,
    output logic [ADDR_W-1:0]   addr1,
    output logic [DATA_W-1:0]   wdata0,
    output logic [DATA_W-1:0]   wdata1,
    input  logic [DATA_W-1:0]   rdata0,
    input  logic [DATA_W-1:0]   rdata1,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*DATA_W-1:0] out_data,
    output logic [1:0]          out_mask,
    output logic                out_last
);

    localparam int FW    = 2 * DATA_W + 3;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [LEN_W-1:0]   left_q, left_d;
    logic [ADDR_W-1:0]  addr0_q, addr0_d;
    logic [ADDR_W-1:0]  addr1_q, addr1_d;
    logic               iss_q, iss_d;
    logic               cap_q, cap_d;
    logic [2:0]         iss_meta_q, iss_meta_d;
    logic [2:0]         cap_meta_q, cap_meta_d;

    logic               issue;
    logic [ADDR_W-1:0]  cur_addr;
    logic [LEN_W-1:0]   cur_left;
    logic               two_left;
    logic [31:0]        occ;
    logic               room;
    logic [FW-1:0]      fifo_wdata;
    logic [FW-1:0]      fifo_rdata;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic               beat_fire;

    function automatic logic [ADDR_W-1:0] wrap_add(
        input logic [ADDR_W-1:0] a,
        input logic [1:0]        inc
    );
        logic [ADDR_W:0] s;
        s = {1'b0, a} + {{(ADDR_W - 1){1'b0}}, inc};
        if (s >= DEPTH_V) begin
            s = s - DEPTH_V;
        end
        return s[ADDR_W-1:0];
    endfunction

    assign wea0   = 4'b0000;
    assign wea1   = 4'b0000;
    assign wdata0 = '0;
    assign wdata1 = '0;
    assign addr0  = addr0_q;
    assign addr1  = addr1_q;
    assign busy   = (state_q != ST_IDLE);

    // Reads in flight count against buffer space so a push always fits.
    assign occ  = 32'(fifo_count) + 32'(iss_q) + 32'(cap_q);
    assign room = (occ < 32'(FIFO_DEPTH));

    // The launch cycle issues straight from the inputs so the first beat
    // appears two edges after start is accepted.
    assign cur_addr = (state_q == ST_IDLE) ? base_addr : ptr_q;
    assign cur_left = (state_q == ST_IDLE) ? length : left_q;
    assign two_left = (cur_left >= LEN_W'(2));

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        left_d     = left_q;
        addr0_d    = addr0_q;
        addr1_d    = addr1_q;
        iss_meta_d = iss_meta_q;
        issue      = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        issue = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                issue = room;
            end
            ST_DRAIN: begin
                if (beat_fire && out_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (issue) begin
            addr0_d    = cur_addr;
            addr1_d    = wrap_add(cur_addr, 2'd1);
            ptr_d      = wrap_add(cur_addr, 2'd2);
            left_d     = cur_left - (two_left ? LEN_W'(2) : LEN_W'(1));
            // {last, mask}
            iss_meta_d = {(cur_left <= LEN_W'(2)), (two_left ? 2'b11 : 2'b01)};
            state_d    = (cur_left <= LEN_W'(2)) ? ST_DRAIN : ST_RUN;
        end

        iss_d      = issue;
        cap_d      = iss_q;
        cap_meta_d = iss_meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            left_q     <= '0;
            addr0_q    <= '0;
            addr1_q    <= '0;
            iss_q      <= 1'b0;
            cap_q      <= 1'b0;
            iss_meta_q <= '0;
            cap_meta_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            left_q     <= left_d;
            addr0_q    <= addr0_d;
            addr1_q    <= addr1_d;
            iss_q      <= iss_d;
            cap_q      <= cap_d;
            iss_meta_q <= iss_meta_d;
            cap_meta_q <= cap_meta_d;
        end
    end

    // SRAM samples the address one edge after issue; data is pushed on the next.
    assign fifo_wdata = {cap_meta_q, rdata1, rdata0};

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cap_q),
        .wdata (fifo_wdata),
        .pop   (beat_fire),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign beat_fire = out_valid && out_ready;
    assign out_data  = out_valid ? fifo_rdata[2*DATA_W-1:0] : '0;
    assign out_mask  = out_valid ? fifo_rdata[2*DATA_W+1:2*DATA_W] : 2'b00;
    assign out_last  = out_valid && fifo_rdata[2*DATA_W+2];

endmodule

// File: tb/tb_sram_weight_reader.sv
// Directed bench for sram_weight_reader with a 1-cycle-latency SRAM model.
// Each beat is checked against its address-derived word pair and hand-computed vectors.
module tb_sram_weight_reader;

    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int DEP = 16384;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [AW-1:0]   base_addr;
    logic [14:0]     length;
    logic            busy;
    logic            done;
    logic [3:0]      wea0, wea1;
    logic [AW-1:0]   addr0, addr1;
    logic [DW-1:0]   wdata0, wdata1;
    logic [DW-1:0]   rdata0, rdata1;
    logic            out_valid;
    logic            out_ready;
    logic [2*DW-1:0] out_data;
    logic [1:0]      out_mask;
    logic            out_last;

    always #5 clk = ~clk;

    sram_weight_reader #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .DEPTH      (DEP),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .wea0      (wea0),
        .wea1      (wea1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mask  (out_mask),
        .out_last  (out_last)
    );

    logic [DW-1:0] mem [DEP];

    always @(posedge clk) begin
        rdata0 <= mem[addr0[13:0]];
        rdata1 <= mem[addr1[13:0]];
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [71:0] got,
                         input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [63:0] bd [32];
    logic [1:0]  bm [32];
    logic        bl [32];
    int          nb, first_v, done_c, last_c, vcnt;

    // mode 0: ready held high; 1: ready 1,0,0,1 repeating;
    // 2: reset on third beat; 3: extra start pulse while busy
    task automatic xfer(input logic [15:0] base, input logic [14:0] len,
                        input int mode);
        logic [67:0] held;
        logic        stalled;
        logic        fin;
        int          k;
        logic [31:0] lo, hi;
        nb      = 0;
        first_v = -1;
        done_c  = -1;
        last_c  = -1;
        vcnt    = 0;
        stalled = 1'b0;
        held    = '0;
        fin     = 1'b0;
        base_addr = base;
        length    = len;
        out_ready = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            if (stalled) begin
                check("hold", 72'({out_valid, out_last, out_mask, out_data}),
                      72'(held));
            end
            if (mode == 2 && nb == 2 && out_valid) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_busy", 72'(busy), 72'(0));
                check("rst_valid", 72'(out_valid), 72'(0));
                check("rst_addr0", 72'(addr0), 72'(0));
                rst = 1'b0;
                return;
            end
            if (mode == 1) out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            if (mode == 3) start = (cyc == 1);
            if (out_valid) begin
                vcnt++;
                if (first_v < 0) first_v = cyc;
            end
            if (out_valid && out_ready) begin
                k  = nb;
                lo = 32'((int'(base) + 2 * k) % DEP);
                hi = 32'((int'(base) + 2 * k + 1) % DEP);
                check("beat_data", 72'(out_data), 72'({hi, lo}));
                check("beat_mask", 72'(out_mask),
                      72'((2 * k + 1 < int'(len)) ? 2'b11 : 2'b01));
                check("beat_last", 72'(out_last),
                      72'(2 * k + 2 >= int'(len)));
                bd[nb] = out_data;
                bm[nb] = out_mask;
                bl[nb] = out_last;
                last_c = cyc;
                nb++;
            end
            stalled = out_valid && !out_ready;
            held    = {out_valid, out_last, out_mask, out_data};
            if (done) begin
                done_c = cyc;
                fin    = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (!fin) check("timeout", 72'(0), 72'(1));
        @(negedge clk);
        check("done_pulse", 72'(done), 72'(0));
        check("idle", 72'(busy), 72'(0));
    endtask

    initial begin
        for (int i = 0; i < DEP; i++) mem[i] = 32'(i);
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy0", 72'(busy), 72'(0));
        check("rst_done0", 72'(done), 72'(0));
        check("rst_outs0",
              72'({out_valid, out_last, out_mask, out_data}), 72'(0));
        check("rst_addr01", 72'({addr0, addr1}), 72'(0));
        check("rst_wr", 72'({wea0, wea1, wdata0, wdata1}), 72'(0));
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 72'(busy), 72'(0));

        // base 0x10, length 8, plus an ignored start while busy
        xfer(16'h0010, 15'd8, 3);
        check("v1_beats", 72'(nb), 72'(4));
        check("v1_b0", 72'(bd[0]), 72'(64'h00000011_00000010));
        check("v1_b3", 72'(bd[3]), 72'(64'h00000017_00000016));
        check("v1_m3", 72'(bm[3]), 72'(2'b11));
        check("v1_l0l3", 72'({bl[0], bl[3]}), 72'(2'b01));
        check("v1_first", 72'(first_v), 72'(2));
        check("v1_done", 72'(done_c), 72'(6));

        // address wrap
        xfer(16'h3FFE, 15'd4, 0);
        check("v2_beats", 72'(nb), 72'(2));
        check("v2_b0", 72'(bd[0]), 72'(64'h00003FFF_00003FFE));
        check("v2_b1", 72'(bd[1]), 72'(64'h00000001_00000000));
        check("v2_addr", 72'({addr0, addr1}), 72'(32'h0000_0001));

        // odd tail
        xfer(16'h0020, 15'd5, 0);
        check("v3_beats", 72'(nb), 72'(3));
        check("v3_b2", 72'(bd[2]), 72'(64'h00000025_00000024));
        check("v3_m2", 72'(bm[2]), 72'(2'b01));
        check("v3_l2", 72'(bl[2]), 72'(1));
        check("v3_m1", 72'(bm[1]), 72'(2'b11));

        // stalling consumer
        xfer(16'h0040, 15'd8, 1);
        check("v4_beats", 72'(nb), 72'(4));
        check("v4_b1", 72'(bd[1]), 72'(64'h00000043_00000042));
        check("v4_b3", 72'(bd[3]), 72'(64'h00000047_00000046));
        check("v4_addr", 72'({addr0, addr1}), 72'(32'h0046_0047));

        // zero length
        xfer(16'h0100, 15'd0, 0);
        check("v5_beats", 72'(nb), 72'(0));
        check("v5_valid", 72'(vcnt), 72'(0));
        check("v5_done", 72'(done_c), 72'(0));
        check("v5_addr", 72'({addr0, addr1}), 72'(32'h0046_0047));

        // reset mid-transfer, then a fresh short transfer
        xfer(16'h0080, 15'd16, 2);
        check("v6_beats", 72'(nb), 72'(2));
        @(negedge clk);
        check("v6_idle", 72'({busy, out_valid}), 72'(0));
        xfer(16'h0100, 15'd2, 0);
        check("v7_beats", 72'(nb), 72'(1));
        check("v7_b0", 72'(bd[0]), 72'(64'h00000101_00000100));
        check("v7_ml", 72'({bm[0], bl[0]}), 72'(3'b111));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
